// File: rtl/aes_axis_packer_pkg.sv
// Shared widths and FSM state encoding for the AES AXI-Stream ingress packer.
package aes_axis_packer_pkg;

  localparam int WORD_S = 32;
  localparam int BLK_S  = 128;

  typedef enum logic [1:0] {
    GET_CMD = 2'd0,
    PACK    = 2'd1,
    PUSH    = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/axis_word_packer.sv
// Four-lane block assembler: word 0 lands in the top lane, unfilled lanes read zero.
module axis_word_packer #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           load,
  input  logic [W-1:0]   din,
  output logic [1:0]     idx,
  output logic [4*W-1:0] blk
);

  logic [3:0][W-1:0] lane_q, lane_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    if (clr) begin
      lane_d = '0;
      idx_d  = '0;
    end else if (load) begin
      lane_d[2'd3 - idx_q] = din;
      idx_d                = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
    end
  end

  assign idx = idx_q;
  assign blk = lane_q;

endmodule

// File: rtl/aes_axis_packer.sv
// AXI-Stream ingress: command capture, 128-bit block packing, FIFO push.
// Define AES_AXIS_BYTE_SWAP_EN to byte-reverse payload words before packing.
module aes_axis_packer
  import aes_axis_packer_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = WORD_S,
  parameter int BLK_WIDTH       = BLK_S
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] aes_cmd,
  output logic                       fifo_write_tvalid,
  input  logic                       fifo_write_tready,
  output logic [BLK_WIDTH-1:0]       fifo_data,
  output logic                       axis_slave_done,
  input  logic                       processing_done,
  output logic [15:0]                block_count
);

  state_e state_q, state_d;

  logic [AXIS_DATA_WIDTH-1:0] cmd_q, cmd_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       last_q, last_d;
  logic                       tready_q, tready_d;
  logic                       tvalid_q, tvalid_d;
  logic                       done_q, done_d;
  logic                       pdone_q, pdone_d;

  logic                       accept, push, pd_rise;
  logic                       clr, load;
  logic [1:0]                 idx;
  logic [AXIS_DATA_WIDTH-1:0] word;

`ifdef AES_AXIS_BYTE_SWAP_EN
  assign word = {s_axis_tdata[7:0],   s_axis_tdata[15:8],
                 s_axis_tdata[23:16], s_axis_tdata[31:24]};
`else
  assign word = s_axis_tdata;
`endif

  assign accept  = s_axis_tvalid && tready_q;
  assign push    = tvalid_q && fifo_write_tready;
  assign pd_rise = processing_done && !pdone_q;
  assign pdone_d = processing_done;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    clr     = 1'b0;
    load    = 1'b0;
    case (state_q)
      GET_CMD: begin
        if (accept) begin
          cmd_d   = s_axis_tdata;
          cnt_d   = '0;
          last_d  = 1'b0;
          clr     = 1'b1;
          state_d = s_axis_tlast ? DONE : PACK;
        end
      end
      PACK: begin
        if (accept) begin
          load = 1'b1;
          if (s_axis_tlast) last_d = 1'b1;
          if (s_axis_tlast || idx == 2'd3) state_d = PUSH;
        end
      end
      PUSH: begin
        if (push) begin
          cnt_d   = cnt_q + 16'd1;
          clr     = 1'b1;
          state_d = last_q ? DONE : PACK;
        end
      end
      DONE: begin
        if (pd_rise) state_d = GET_CMD;
      end
      default: begin
        state_d = GET_CMD;
        clr     = 1'b1;
      end
    endcase
    // Handshake outputs are registered from the next state.
    tready_d = (state_d == GET_CMD) || (state_d == PACK);
    tvalid_d = (state_d == PUSH);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GET_CMD;
      cmd_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      pdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      pdone_q  <= pdone_d;
    end
  end

  axis_word_packer #(
    .W (AXIS_DATA_WIDTH)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .load  (load),
    .din   (word),
    .idx   (idx),
    .blk   (fifo_data)
  );

  assign s_axis_tready     = tready_q;
  assign fifo_write_tvalid = tvalid_q;
  assign axis_slave_done   = done_q;
  assign aes_cmd           = cmd_q;
  assign block_count       = cnt_q;

endmodule

// File: tb/tb_aes_axis_packer.sv
// Directed, table-driven bench for aes_axis_packer with a FIFO-side scoreboard.
module tb_aes_axis_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [31:0]  aes_cmd;
  logic         fifo_write_tvalid;
  logic         fifo_write_tready;
  logic [127:0] fifo_data;
  logic         axis_slave_done;
  logic         processing_done;
  logic [15:0]  block_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] got_q[$];

  always #5 clk = ~clk;

  aes_axis_packer dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .aes_cmd           (aes_cmd),
    .fifo_write_tvalid (fifo_write_tvalid),
    .fifo_write_tready (fifo_write_tready),
    .fifo_data         (fifo_data),
    .axis_slave_done   (axis_slave_done),
    .processing_done   (processing_done),
    .block_count       (block_count)
  );

  always @(posedge clk)
    if (!reset && fifo_write_tvalid && fifo_write_tready)
      got_q.push_back(fifo_data);

  typedef struct {
    logic [31:0]        cmd;
    int                 n;
    logic [7:0][31:0]   w;
    int                 nblk;
    logic [1:0][127:0]  b;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] xb(input logic [127:0] b);
    logic [127:0] r;
    logic [31:0]  l;
    r = b;
`ifdef AES_AXIS_BYTE_SWAP_EN
    for (int i = 0; i < 4; i++) begin
      l = b[i*32 +: 32];
      r[i*32 +: 32] = {l[7:0], l[15:8], l[23:16], l[31:24]};
    end
`endif
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: tready stuck at %b, required 1", s_axis_tready);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!axis_slave_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", {127'd0, axis_slave_done}, 128'd1);
  endtask

  task automatic release_done();
    processing_done = 1'b0;
    @(negedge clk);
    processing_done = 1'b1;
    @(negedge clk);
    check("done_release", {127'd0, axis_slave_done}, 128'd0);
    check("ready_after_release", {127'd0, s_axis_tready}, 128'd1);
    processing_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, {127'd0, s_axis_tready}, 128'd0);
    check({tag, "_tvalid"}, {127'd0, fifo_write_tvalid}, 128'd0);
    check({tag, "_done"}, {127'd0, axis_slave_done}, 128'd0);
    check({tag, "_cmd"}, {96'd0, aes_cmd}, 128'd0);
    check({tag, "_cnt"}, {112'd0, block_count}, 128'd0);
    check({tag, "_data"}, fifo_data, 128'd0);
  endtask

  logic [127:0] held;

  initial begin
    reset             = 1'b1;
    s_axis_tdata      = '0;
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    fifo_write_tready = 1'b1;
    processing_done   = 1'b0;

    vecs[0].cmd = 32'h0000_0011; vecs[0].n = 4;
    vecs[0].w = {32'h0, 32'h0, 32'h0, 32'h0,
                 32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    vecs[0].nblk = 1;
    vecs[0].b = {128'h0,
                 128'h00112233_44556677_8899AABB_CCDDEEFF};

    vecs[1].cmd = 32'h0000_0022; vecs[1].n = 6;
    vecs[1].w = {32'h0, 32'h0, 32'h06060606, 32'h05050505,
                 32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    vecs[1].nblk = 2;
    vecs[1].b = {128'h05050505_06060606_00000000_00000000,
                 128'h01010101_02020202_03030303_04040404};

    vecs[2].cmd = 32'h0000_0033; vecs[2].n = 0;
    vecs[2].w = '0;
    vecs[2].nblk = 0;
    vecs[2].b = '0;

    vecs[3].cmd = 32'hA5A5_0044; vecs[3].n = 1;
    vecs[3].w = {224'h0, 32'hDEADBEEF};
    vecs[3].nblk = 1;
    vecs[3].b = {128'h0, 128'hDEADBEEF_00000000_00000000_00000000};

    vecs[4].cmd = 32'h0000_0055; vecs[4].n = 8;
    vecs[4].w = {32'h80000008, 32'h70000007, 32'h60000006, 32'h50000005,
                 32'h40000004, 32'h30000003, 32'h20000002, 32'h10000001};
    vecs[4].nblk = 2;
    vecs[4].b = {128'h50000005_60000006_70000007_80000008,
                 128'h10000001_20000002_30000003_40000004};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("first_ready", {127'd0, s_axis_tready}, 128'd1);

`ifdef AES_AXIS_BYTE_SWAP_EN
    check("swap_example", xb(128'h00112233), 128'h33221100);
`endif

    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      send(vecs[v].cmd, vecs[v].n == 0);
      if (vecs[v].n == 0)
        check("empty_done_1cyc", {127'd0, axis_slave_done}, 128'd1);
      for (int i = 0; i < vecs[v].n; i++)
        send(vecs[v].w[i], i == vecs[v].n - 1);
      wait_done();
      check($sformatf("v%0d_cmd", v), {96'd0, aes_cmd}, {96'd0, vecs[v].cmd});
      check($sformatf("v%0d_cnt", v), {112'd0, block_count},
            128'(vecs[v].nblk));
      check($sformatf("v%0d_nblk", v), 128'(got_q.size()),
            128'(vecs[v].nblk));
      for (int b = 0; b < vecs[v].nblk; b++)
        if (b < got_q.size())
          check($sformatf("v%0d_blk%0d", v, b), got_q[b], xb(vecs[v].b[b]));
      release_done();
    end

    // backpressure on the second of three blocks
    got_q.delete();
    send(32'h0000_0066, 1'b0);
    for (int i = 0; i < 8; i++)
      send(32'hB000_0000 + 32'(i), 1'b0);
    fifo_write_tready = 1'b0;
    check("stall_tvalid_rise", {127'd0, fifo_write_tvalid}, 128'd1);
    held = fifo_data;
    check("stall_blk2", held,
          xb(128'hB0000004_B0000005_B0000006_B0000007));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_tready", {127'd0, s_axis_tready}, 128'd0);
      check("stall_data", fifo_data, held);
    end
    fifo_write_tready = 1'b1;
    for (int i = 8; i < 12; i++)
      send(32'hB000_0000 + 32'(i), i == 11);
    wait_done();
    check("stall_nblk", 128'(got_q.size()), 128'd3);
    check("stall_cnt", {112'd0, block_count}, 128'd3);
    if (got_q.size() == 3) begin
      check("stall_b0", got_q[0], xb(128'hB0000000_B0000001_B0000002_B0000003));
      check("stall_b1", got_q[1], held);
      check("stall_b2", got_q[2], xb(128'hB0000008_B0000009_B000000A_B000000B));
    end
    release_done();

    // processing_done already high on entry to DONE must not release it
    processing_done = 1'b1;
    send(32'h0000_0099, 1'b1);
    repeat (5) @(negedge clk);
    check("pd_level_hold", {127'd0, axis_slave_done}, 128'd1);
    check("pd_level_tready", {127'd0, s_axis_tready}, 128'd0);
    release_done();

    // reset after two data words discards the partial block
    got_q.delete();
    send(32'h0000_00EE, 1'b0);
    send(32'hFFFF_0001, 1'b0);
    send(32'hFFFF_0002, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    send(32'h0000_0077, 1'b0);
    send(32'hC0000001, 1'b0);
    send(32'hC0000002, 1'b0);
    send(32'hC0000003, 1'b0);
    send(32'hC0000004, 1'b1);
    wait_done();
    check("rst_nblk", 128'(got_q.size()), 128'd1);
    if (got_q.size() == 1)
      check("rst_blk", got_q[0],
            xb(128'hC0000001_C0000002_C0000003_C0000004));
    check("rst_cmd", {96'd0, aes_cmd}, 128'h77);
    release_done();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
